// File: rtl/fv_ram_pkg.sv
// Shared types and helpers for the RAM request controller and its harnesses.
package fv_ram_pkg;

  localparam int unsigned DATW_DEF = 32;
  localparam int unsigned BEW_DEF  = DATW_DEF / 8;

  typedef struct packed {
    logic                write;
    logic [DATW_DEF-1:0] rdata;
  } rsp_t;

  // Expands per-byte enables into a per-bit write mask.
  function automatic logic [DATW_DEF-1:0] be_mask(input logic [BEW_DEF-1:0] be);
    logic [DATW_DEF-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BEW_DEF; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/fv_dp_ram.sv
// Single-clock RAM with byte-lane writes and a 1-cycle registered read (read-old on collision).
module fv_dp_ram
  import fv_ram_pkg::*;
#(
  parameter int unsigned ADDW = 16,
  parameter int unsigned DATW = DATW_DEF
) (
  input  logic              i_clk,
  input  logic [DATW/8-1:0] i_we,
  input  logic [ADDW-1:0]   i_wr_addr,
  input  logic [ADDW-1:0]   i_rd_addr,
  input  logic [DATW-1:0]   i_d,
  output logic [DATW-1:0]   o_q
);

  logic [DATW-1:0] r_mem [2**ADDW];

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < DATW / 8; i++) begin
      if (i_we[i]) begin
        r_mem[i_wr_addr][i*8 +: 8] <= i_d[i*8 +: 8];
      end
    end
    o_q <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/fv_rsp_fifo.sv
// Circular-buffer response FIFO; push and pop may coincide, including when full.
module fv_rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/fv_ram_req_ctrl.sv
// Request/response front-end for a byte-enabled RAM: in-flight stage plus credit-limited
// response FIFO keeps responses in request order.
module fv_ram_req_ctrl
  import fv_ram_pkg::*;
#(
  parameter int unsigned ADDW      = 16,
  parameter int unsigned DATW      = DATW_DEF,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDW-1:0]   req_addr,
  input  logic [DATW-1:0]   req_wdata,
  input  logic [DATW/8-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATW-1:0]   rsp_rdata,
  output logic [ADDW-1:0]   ram_wr_addr,
  output logic [ADDW-1:0]   ram_rd_addr,
  output logic [DATW-1:0]   ram_d,
  output logic [DATW/8-1:0] ram_we,
  input  logic [DATW-1:0]   ram_q
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  if ((DATW % 8) != 0) begin : g_bad_datw
    $error("fv_ram_req_ctrl: DATW must be a multiple of 8");
  end
  if (RSP_DEPTH < 2) begin : g_bad_depth
    $error("fv_ram_req_ctrl: RSP_DEPTH must be at least 2");
  end

  logic            r_inf_valid;
  logic            r_inf_write;
  logic [31:0]     r_rd_cnt;
  logic [31:0]     r_wr_cnt;
  logic            w_fire;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic [DATW:0]   w_push_data;
  logic [DATW:0]   w_head;

  // Credit covers both the FIFO and the in-flight slot, so a push always has room.
  assign w_used    = {1'b0, w_count} + (CW+1)'(r_inf_valid);
  assign req_ready = !rst && (w_used < (CW+1)'(RSP_DEPTH));
  assign w_fire    = req_valid && req_ready;

  assign ram_wr_addr = req_addr;
  assign ram_rd_addr = req_addr;
  assign ram_d       = req_wdata;
  assign ram_we      = (w_fire && req_write) ? req_be : '0;

  assign w_push_data = {r_inf_write, (r_inf_write ? {DATW{1'b0}} : ram_q)};
  assign w_pop       = rsp_valid && rsp_ready;

  assign rsp_valid = !w_empty;
  assign rsp_write = !w_empty && w_head[DATW];
  assign rsp_rdata = w_empty ? '0 : w_head[DATW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inf_valid <= 1'b0;
      r_inf_write <= 1'b0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_inf_valid <= w_fire;
      r_inf_write <= req_write;
      if (w_fire && !req_write && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_fire && req_write && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(r_inf_valid && w_full && !w_pop))
        else $error("fv_ram_req_ctrl: response FIFO overflow");
    end
  end

  fv_rsp_fifo #(
    .WIDTH (DATW + 1),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_inf_valid),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_fv_ram_req_ctrl.sv
// Bench for fv_ram_req_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_fv_ram_req_ctrl;
  import fv_ram_pkg::*;

  localparam int unsigned ADDW  = 16;
  localparam int unsigned DATW  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [ADDW-1:0] req_addr;
  logic [DATW-1:0] req_wdata;
  logic [3:0]      req_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_write;
  logic [DATW-1:0] rsp_rdata;
  logic [ADDW-1:0] ram_wr_addr;
  logic [ADDW-1:0] ram_rd_addr;
  logic [DATW-1:0] ram_d;
  logic [3:0]      ram_we;
  logic [DATW-1:0] ram_q;

  fv_ram_req_ctrl #(.ADDW(ADDW), .DATW(DATW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr), .ram_d(ram_d),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  fv_dp_ram #(.ADDW(ADDW), .DATW(DATW)) u_ram (
    .i_clk(clk), .i_we(ram_we), .i_wr_addr(ram_wr_addr), .i_rd_addr(ram_rd_addr),
    .i_d(ram_d), .o_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] d;
    int          t;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fires = 0;
  int          stalls = 0;
  int unsigned n_rd = 0;
  int unsigned n_wr = 0;
  bit          rand_mode = 0;
  logic [31:0] mem_m [16];
  ent_t        mq[$];
  rsp_t        plog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: every accepted request becomes a queue entry visible two cycles later.
  always @(negedge clk) begin
    logic       exp_valid, exp_ready, exp_fire;
    logic [3:0] exp_we;
    logic [3:0] a;
    ent_t       e;
    cyc++;
    exp_valid = (mq.size() > 0) && (cyc >= mq[0].t + 1);
    exp_ready = !rst && (mq.size() < DEPTH);
    exp_fire  = req_valid && exp_ready;
    exp_we    = (exp_fire && req_write) ? req_be : 4'h0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_valid) begin
      chk("rsp_write", 32'(rsp_write), 32'(mq[0].w));
      chk("rsp_rdata", rsp_rdata, mq[0].d);
    end
    if (req_valid) begin
      chk("ram_rd_addr", 32'(ram_rd_addr), 32'(req_addr));
      chk("ram_wr_addr", 32'(ram_wr_addr), 32'(req_addr));
      chk("ram_d", ram_d, req_wdata);
    end
    if (rsp_valid && rsp_ready) plog.push_back('{write: rsp_write, rdata: rsp_rdata});
    if (rst) begin
      mq.delete();
      n_rd = 0;
      n_wr = 0;
    end else begin
      if (exp_valid && rsp_ready) void'(mq.pop_front());
      if (exp_fire) begin
        fires++;
        a = req_addr[3:0];
        e.t = cyc + 1;
        if (req_write) begin
          mem_m[a] = (mem_m[a] & ~be_mask(req_be)) | (req_wdata & be_mask(req_be));
          e.w = 1'b1;
          e.d = 32'h0;
          n_wr++;
        end else begin
          e.w = 1'b0;
          e.d = mem_m[a];
          n_rd++;
        end
        mq.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic w, input logic [ADDW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    int   n;
    logic acc;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc) stalls++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (plog.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (plog.size() < n) chk("rsp_timeout", 32'(plog.size()), 32'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int l0, f0, s0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_write", 32'(rsp_write), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) send(1'b1, ADDW'(i), 32'h5A00_0000 | 32'(i), 4'hF);
    idle(4);

    l0 = plog.size();
    send(1'b1, 16'd5, 32'hCAFE_DA21, 4'hF);
    send(1'b0, 16'd5, 32'h0, 4'h0);
    wait_log(l0 + 2);
    chk("wr_ack_write", 32'(plog[l0].write), 32'd1);
    chk("wr_ack_rdata", plog[l0].rdata, 32'h0);
    chk("rd5_write", 32'(plog[l0+1].write), 32'd0);
    chk("rd5_rdata", plog[l0+1].rdata, 32'hCAFE_DA21);

    l0 = plog.size();
    send(1'b1, 16'd0, 32'hFEED_BEEF, 4'hF);
    send(1'b1, 16'd0, 32'h1122_3344, 4'b0101);
    send(1'b0, 16'd0, 32'h0, 4'h0);
    wait_log(l0 + 3);
    chk("byte_lane_rdata", plog[l0+2].rdata, 32'hFE22_BE44);

    l0 = plog.size();
    send(1'b1, 16'd7, 32'hA5A5_A5A5, 4'hF);
    send(1'b0, 16'd7, 32'h0, 4'h0);
    wait_log(l0 + 2);
    chk("raw_rdata", plog[l0+1].rdata, 32'hA5A5_A5A5);
    idle(4);

    // Backpressure: four credits, then stall until the consumer drains.
    rsp_ready = 1'b0;
    l0 = plog.size();
    f0 = fires;
    send(1'b0, 16'd1, 32'h0, 4'h0);
    send(1'b0, 16'd2, 32'h0, 4'h0);
    send(1'b0, 16'd3, 32'h0, 4'h0);
    send(1'b0, 16'd4, 32'h0, 4'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd6;
    repeat (5) @(negedge clk);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_accepted", 32'(fires - f0), 32'd4);
    chk("bp_no_pop", 32'(plog.size() - l0), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b0, 16'd6, 32'h0, 4'h0);
    send(1'b0, 16'd8, 32'h0, 4'h0);
    wait_log(l0 + 6);
    chk("bp_rsp0", plog[l0].rdata, 32'h5A00_0001);
    chk("bp_rsp1", plog[l0+1].rdata, 32'h5A00_0002);
    chk("bp_rsp2", plog[l0+2].rdata, 32'h5A00_0003);
    chk("bp_rsp3", plog[l0+3].rdata, 32'h5A00_0004);
    chk("bp_rsp4", plog[l0+4].rdata, 32'h5A00_0006);
    chk("bp_rsp5", plog[l0+5].rdata, 32'h5A00_0008);
    idle(4);

    l0 = plog.size();
    s0 = stalls;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, ADDW'(i), $urandom, 4'hF);
      send(1'b0, ADDW'(i), 32'h0, 4'h0);
    end
    idle(2);
    chk("tput_stalls", 32'(stalls - s0), 32'd0);
    chk("tput_rsps", 32'(plog.size() - l0), 32'd20);
    idle(4);

    send(1'b0, 16'd3, 32'h0, 4'h0);
    rst = 1'b1;
    l0 = plog.size();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd3; req_be = 4'hF;
    req_wdata = 32'hDEAD_0000;
    idle(2);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    idle(5);
    chk("rst_no_rsp", 32'(plog.size() - l0), 32'd0);

    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), ADDW'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_mode = 0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    idle(10);
    chk("model_drained", 32'(mq.size()), 32'd0);
    chk("rd_cnt", dut.r_rd_cnt, 32'(n_rd));
    chk("wr_cnt", dut.r_wr_cnt, 32'(n_wr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
